// File: rtl/energy_lut_arb_if.sv
// Lookup, coefficient-update and result channels of the energy coefficient LUT arbiter.
interface energy_lut_arb_if #(
   parameter int AW = 10,
   parameter int DW = 64
);
   logic          lk_valid;
   logic          lk_ready;
   logic [AW-1:0] lk_addr;
   logic [15:0]   lk_tag;
   logic          upd_valid;
   logic          upd_ready;
   logic [AW-1:0] upd_addr;
   logic [DW-1:0] upd_data;
   logic          out_valid;
   logic [DW-1:0] out_coeff;
   logic [15:0]   out_tag;

   modport master (
      output lk_valid, lk_addr, lk_tag, upd_valid, upd_addr, upd_data,
      input  lk_ready, upd_ready, out_valid, out_coeff, out_tag
   );
   modport slave (
      input  lk_valid, lk_addr, lk_tag, upd_valid, upd_addr, upd_data,
      output lk_ready, upd_ready, out_valid, out_coeff, out_tag
   );
endinterface

// File: rtl/energy_lut_arb.sv
// Single-port coefficient LUT arbiter: lookups win by default, starved updates are forced
// after STARVE_MAX losing cycles; lookup results return through a fixed-latency pipeline.
module energy_lut_arb #(
   parameter int AW         = 10,
   parameter int DW         = 64,
   parameter int RD_LAT     = 2,
   parameter int STARVE_MAX = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   energy_lut_arb_if.slave bus,
   output logic          bram_en_a,
   output logic          bram_we,
   output logic [AW-1:0] bram_addr,
   output logic [DW-1:0] bram_wr_data,
   input  logic [DW-1:0] bram_rd_data,
   output logic [4:0]    starve_cnt,
   output logic [15:0]   forced_cnt
);
   localparam logic [4:0] SMAX = 5'(STARVE_MAX);

   typedef enum logic {RUN, FORCE} state_t;

   state_t                 r_state, w_state_nxt;
   logic [4:0]             r_starve, w_starve_nxt;
   logic [15:0]            r_forced;
   logic                   w_lk_rdy, w_upd_rdy, w_lk_go, w_upd_go;
   logic [RD_LAT:0]        r_vld_pipe;
   logic [RD_LAT:0][15:0]  r_tag_pipe;
   logic [DW-1:0]          r_coeff;

   // Readies are gated by rst_n so nothing is granted while reset is held.
   always_comb begin
      w_state_nxt  = r_state;
      w_starve_nxt = r_starve;
      w_lk_rdy     = 1'b0;
      w_upd_rdy    = 1'b0;
      if (rst_n) begin
         case (r_state)
            RUN: begin
               w_lk_rdy  = 1'b1;
               w_upd_rdy = ~bus.lk_valid;
               if (bus.upd_valid && bus.lk_valid) begin
                  if (r_starve < SMAX) w_starve_nxt = r_starve + 5'd1;
                  if (r_starve == SMAX - 5'd1) w_state_nxt = FORCE;
               end else begin
                  w_starve_nxt = 5'd0;
               end
            end
            FORCE: begin
               w_upd_rdy    = 1'b1;
               w_state_nxt  = RUN;
               w_starve_nxt = 5'd0;
            end
            default: w_state_nxt = RUN;
         endcase
      end
   end

   assign w_lk_go  = bus.lk_valid  & w_lk_rdy;
   assign w_upd_go = bus.upd_valid & w_upd_rdy;

   assign bram_en_a    = w_lk_go | w_upd_go;
   assign bram_we      = w_upd_go;
   assign bram_addr    = w_upd_go ? bus.upd_addr : bus.lk_addr;
   assign bram_wr_data = bus.upd_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= RUN;
         r_starve <= 5'd0;
         r_forced <= 16'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_starve <= w_starve_nxt;
         if (r_state == FORCE && w_upd_go && r_forced != 16'hFFFF)
            r_forced <= r_forced + 16'd1;
      end
   end

   // Stage RD_LAT-1 marks the cycle the LUT output register holds this lookup's word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_pipe <= '0;
         r_tag_pipe <= '0;
         r_coeff    <= '0;
      end else begin
         r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_lk_go};
         r_tag_pipe <= {r_tag_pipe[RD_LAT-1:0], bus.lk_tag};
         if (r_vld_pipe[RD_LAT-1]) r_coeff <= bram_rd_data;
      end
   end

   assign bus.lk_ready  = w_lk_rdy;
   assign bus.upd_ready = w_upd_rdy;
   assign bus.out_valid = r_vld_pipe[RD_LAT];
   assign bus.out_tag   = r_tag_pipe[RD_LAT];
   assign bus.out_coeff = r_coeff;
   assign starve_cnt    = r_starve;
   assign forced_cnt    = r_forced;
endmodule

// File: tb/tb_energy_lut_arb.sv
// Directed bench for energy_lut_arb with a write-first, two-register LUT model on port A.
module tb_energy_lut_arb;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        bram_en_a, bram_we;
   logic [9:0]  bram_addr;
   logic [63:0] bram_wr_data, bram_rd_data;
   logic [4:0]  starve_cnt;
   logic [15:0] forced_cnt;
   int          n_tests = 0;
   int          n_fail  = 0;

   energy_lut_arb_if #(.AW(10), .DW(64)) bus();

   energy_lut_arb #(.AW(10), .DW(64), .RD_LAT(2), .STARVE_MAX(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .bram_en_a(bram_en_a), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wr_data(bram_wr_data), .bram_rd_data(bram_rd_data),
      .starve_cnt(starve_cnt), .forced_cnt(forced_cnt)
   );

   always #5 clk = ~clk;

   // LUT model: preloaded pattern unless overwritten; write-first; core + output register.
   logic [63:0] wmem [0:1023];
   bit          wflag [0:1023];
   logic [63:0] s1, s2;

   function automatic logic [63:0] lut_init(input logic [9:0] a);
      if (a == 10'd5) return 64'h0123456789ABCDEF;
      return 64'hC0EF_0000_0000_0000 | {54'd0, a};
   endfunction

   always @(posedge clk) begin
      if (bram_en_a) begin
         if (bram_we) begin
            wmem[bram_addr]  <= bram_wr_data;
            wflag[bram_addr] <= 1'b1;
            s1 <= bram_wr_data;
         end else begin
            s1 <= wflag[bram_addr] ? wmem[bram_addr] : lut_init(bram_addr);
         end
      end
      s2 <= s1;
   end
   assign bram_rd_data = s2;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.lk_valid  = 1'b0;
      bus.upd_valid = 1'b0;
   endtask

   task automatic lk(input logic [9:0] a, input logic [15:0] t);
      bus.lk_valid = 1'b1;
      bus.lk_addr  = a;
      bus.lk_tag   = t;
   endtask

   task automatic upd(input logic [9:0] a, input logic [63:0] d);
      bus.upd_valid = 1'b1;
      bus.upd_addr  = a;
      bus.upd_data  = d;
   endtask

   initial begin
      idle();
      bus.lk_addr = '0; bus.lk_tag = '0; bus.upd_addr = '0; bus.upd_data = '0;
      #1 rst_n = 1'b0;
      lk(10'd1, 16'h1111);
      upd(10'd2, 64'h22);
      #1;
      chk("rst_lk_ready", bus.lk_ready, 0);
      chk("rst_upd_ready", bus.upd_ready, 0);
      chk("rst_en", bram_en_a, 0);
      chk("rst_we", bram_we, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_coeff", bus.out_coeff, 0);
      chk("rst_tag", bus.out_tag, 0);
      chk("rst_starve", starve_cnt, 0);
      chk("rst_forced", forced_cnt, 0);
      idle();
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Single lookup latency
      cyc(); lk(10'd5, 16'h00AA); #1;
      chk("lk_en", bram_en_a, 1);
      chk("lk_we", bram_we, 0);
      chk("lk_addr", bram_addr, 5);
      cyc(); idle(); #1; chk("lat_n1", bus.out_valid, 0);
      cyc(); #1; chk("lat_n2", bus.out_valid, 0);
      cyc(); #1;
      chk("lat_n3_valid", bus.out_valid, 1);
      chk("lat_n3_coeff", bus.out_coeff, 64'h0123456789ABCDEF);
      chk("lat_n3_tag", bus.out_tag, 16'h00AA);
      cyc(); #1; chk("lat_n4", bus.out_valid, 0);

      // Back-to-back lookups 0..7
      for (int k = 0; k < 12; k++) begin
         cyc();
         if (k < 8) lk(10'(k), 16'h0100 + 16'(k)); else idle();
         #1;
         if (k >= 3 && k < 11) begin
            chk("b2b_valid", bus.out_valid, 1);
            chk("b2b_coeff", bus.out_coeff, lut_init(10'(k - 3)));
            chk("b2b_tag", bus.out_tag, 16'h0100 + 16'(k - 3));
         end else begin
            chk("b2b_idle", bus.out_valid, 0);
         end
      end

      // Starvation: update forced in the 17th contended cycle
      for (int c = 1; c <= 17; c++) begin
         cyc();
         lk(10'd1, 16'h0360 + 16'(c));
         upd(10'd20, 64'hDEAD_BEEF_0000_0014);
         #1;
         chk("starve_lk_ready", bus.lk_ready, (c != 17));
         chk("starve_upd_ready", bus.upd_ready, (c == 17));
         chk("starve_cnt", starve_cnt, (c <= 16) ? 64'(c - 1) : 64'd16);
         chk("starve_we", bram_we, (c == 17));
      end
      cyc(); idle(); #1;
      chk("force_cnt", forced_cnt, 1);
      chk("force_starve_clr", starve_cnt, 0);
      chk("force_back_run", bus.lk_ready, 1);
      repeat (3) cyc();

      // Read-after-write, including the address written by the forced update
      cyc(); upd(10'd9, 64'hFFFF0000FFFF0000); #1;
      chk("raw_we", bram_we, 1);
      chk("raw_addr", bram_addr, 9);
      chk("raw_wdata", bram_wr_data, 64'hFFFF0000FFFF0000);
      cyc(); idle(); lk(10'd9, 16'h0909); #1;
      chk("raw_lk_en", bram_en_a, 1);
      cyc(); lk(10'd20, 16'h2020); #1;
      cyc(); idle(); #1;
      cyc(); #1;
      chk("raw_valid", bus.out_valid, 1);
      chk("raw_coeff", bus.out_coeff, 64'hFFFF0000FFFF0000);
      chk("raw_tag", bus.out_tag, 16'h0909);
      cyc(); #1;
      chk("forced_data", bus.out_coeff, 64'hDEAD_BEEF_0000_0014);
      chk("forced_tag", bus.out_tag, 16'h2020);

      // Uncontended updates: granted immediately, no results
      for (int i = 0; i < 4; i++) begin
         cyc(); upd(10'(30 + i), 64'(i)); #1;
         chk("upd_ready", bus.upd_ready, 1);
         chk("upd_we", bram_we, 1);
         chk("upd_starve", starve_cnt, 0);
         chk("upd_no_out", bus.out_valid, 0);
      end
      cyc(); idle(); #1;
      chk("upd_forced_same", forced_cnt, 1);
      chk("upd_no_out_tail", bus.out_valid, 0);

      // Reset with lookups in flight
      for (int k = 0; k < 3; k++) begin
         cyc(); lk(10'(10 + k), 16'h0A00 + 16'(k)); #1;
      end
      cyc(); idle(); #1;
      chk("inflight_valid", bus.out_valid, 1);
      rst_n = 1'b0;
      lk(10'd4, 16'h0404);
      #1;
      chk("arst_valid", bus.out_valid, 0);
      chk("arst_coeff", bus.out_coeff, 0);
      chk("arst_tag", bus.out_tag, 0);
      chk("arst_forced", forced_cnt, 0);
      chk("arst_lk_ready", bus.lk_ready, 0);
      chk("arst_en", bram_en_a, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      lk(10'd3, 16'h0303);
      #1;
      chk("rel_lk_ready", bus.lk_ready, 1);
      chk("rel_en", bram_en_a, 1);
      cyc(); idle(); #1; chk("rel_n1", bus.out_valid, 0);
      cyc(); #1; chk("rel_n2", bus.out_valid, 0);
      cyc(); #1;
      chk("rel_n3_valid", bus.out_valid, 1);
      chk("rel_n3_coeff", bus.out_coeff, lut_init(10'd3));
      chk("rel_n3_tag", bus.out_tag, 16'h0303);
      cyc(); #1; chk("rel_n4", bus.out_valid, 0);
      cyc(); #1; chk("rel_n5", bus.out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
